// File: rtl/cpu_controller.sv
// Instruction register, decoder and Moore control FSM driving the datapath.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap in HALT with err=1.
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic [15:0] datapath_in,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        err
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_GETA   = 3'd2;
  localparam logic [2:0] S_GETB   = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WRREG  = 3'd5;
  localparam logic [2:0] S_WRIMM  = 3'd6;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_HALT   = 3'd7;
`endif

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movimm, is_movreg, is_alu, is_cmp, is_mvn;

  assign opc = ir_q[15:13];
  assign op  = ir_q[12:11];
  assign rn  = ir_q[10:8];
  assign rd  = ir_q[7:5];
  assign sh  = ir_q[4:3];
  assign rm  = ir_q[2:0];

  assign is_movimm = (opc == 3'b110) && (op == 2'b10);
  assign is_movreg = (opc == 3'b110) && (op == 2'b00);
  assign is_alu    = (opc == 3'b101);
  assign is_cmp    = is_alu && (op == 2'b01);
  assign is_mvn    = is_alu && (op == 2'b11);

  assign datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};
  assign w           = (state_q == S_WAIT);
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign err = (state_q == S_HALT);
`else
  assign err = 1'b0;
`endif

  // IR captures only while idle, so a load with start decodes the new word
  assign ir_d = (state_q == S_WAIT && load) ? in : ir_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (s) state_d = S_DECODE;
      S_DECODE: begin
        if (is_movimm)              state_d = S_WRIMM;
        else if (is_movreg || is_mvn) state_d = S_GETB;
        else if (is_alu)            state_d = S_GETA;
`ifdef CTRL_ILLEGAL_TRAP_EN
        else                        state_d = S_HALT;
`else
        else                        state_d = S_WAIT;
`endif
      end
      S_GETA:   state_d = S_GETB;
      S_GETB:   state_d = S_EXEC;
      S_EXEC:   state_d = is_cmp ? S_WAIT : S_WRREG;
      S_WRREG:  state_d = S_WAIT;
      S_WRIMM:  state_d = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_WAIT;
    endcase
  end

  always_comb begin
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      // MOV reg zeroes the A side so the ALU add yields the shifted B operand
      S_EXEC: begin
        shift = sh;
        ALUop = op;
        loadc = 1'b1;
        loads = is_cmp;
        asel  = is_movreg;
      end
      S_WRREG: begin
        writenum = rd;
        write    = 1'b1;
      end
      S_WRIMM: begin
        vsel     = 1'b1;
        writenum = rn;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller: per-cycle control vectors
// for each instruction class, reset behaviour, IR capture rules and illegal opcodes.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic [15:0] datapath_in;
  logic        loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic        err;

  int checks = 0;
  int errors = 0;

  cpu_controller dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .datapath_in(datapath_in), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop), .err(err)
  );

  always #5 clk = ~clk;

  // {w, err, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel, shift, ALUop}
  logic [19:0] ctl;
  assign ctl = {w, err, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                asel, bsel, shift, ALUop};

  localparam logic [7:0] ST_NONE  = 8'b0000_0000;
  localparam logic [7:0] ST_GETA  = 8'b0010_0000;
  localparam logic [7:0] ST_GETB  = 8'b0001_0000;
  localparam logic [7:0] ST_EXEC  = 8'b0000_1000;
  localparam logic [7:0] ST_CMP   = 8'b0000_1100;
  localparam logic [7:0] ST_MOVR  = 8'b0000_1010;
  localparam logic [7:0] ST_WRREG = 8'b1000_0000;
  localparam logic [7:0] ST_WRIMM = 8'b1100_0000;

  function automatic logic [19:0] ev(input logic wv, input logic [2:0] rdn,
                                     input logic [2:0] wrn, input logic [7:0] st,
                                     input logic [1:0] shv, input logic [1:0] opv);
    return {wv, 1'b0, rdn, wrn, st, shv, opv};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in = 16'h0000; load = 1'b0; s = 1'b0;
    #3;
    checks++;
    if (ctl !== ev(1, 0, 0, ST_NONE, 0, 0)) begin
      errors++; $display("FAIL reset_ctl got=%h exp=%h", ctl, ev(1, 0, 0, ST_NONE, 0, 0));
    end
    checks++;
    if (datapath_in !== 16'h0000) begin
      errors++; $display("FAIL reset_dpin got=%h exp=0000", datapath_in);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (ctl !== ev(1, 0, 0, ST_NONE, 0, 0)) begin
      errors++; $display("FAIL idle_ctl got=%h exp=%h", ctl, ev(1, 0, 0, ST_NONE, 0, 0));
    end
  endtask

  task automatic test_movimm(input logic [15:0] word, input logic [2:0] rnx,
                             input logic [15:0] dpin);
    logic [19:0] seq [0:2];
    seq = '{ev(0, 0, 0, ST_NONE, 0, 0), ev(0, 0, rnx, ST_WRIMM, 0, 0),
            ev(1, 0, 0, ST_NONE, 0, 0)};
    in = word; load = 1'b1; s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      load = 1'b0; s = 1'b0;
      checks++;
      if (ctl !== seq[i]) begin
        errors++; $display("FAIL movimm_%h_c%0d got=%h exp=%h", word, i, ctl, seq[i]);
      end
      if (i == 1) begin
        checks++;
        if (datapath_in !== dpin) begin
          errors++; $display("FAIL movimm_%h_dpin got=%h exp=%h", word, datapath_in, dpin);
        end
      end
    end
  endtask

  task automatic test_add();
    logic [19:0] seq [0:4];
    seq = '{ev(0, 0, 0, ST_NONE, 0, 0), ev(0, 3'b001, 0, ST_GETA, 0, 0),
            ev(0, 3'b000, 0, ST_GETB, 0, 0), ev(0, 0, 0, ST_EXEC, 2'b01, 2'b00),
            ev(0, 0, 3'b010, ST_WRREG, 0, 0)};
    in = 16'hA148; load = 1'b1; s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0; s = 1'b0;
      checks++;
      if (ctl !== seq[i]) begin
        errors++; $display("FAIL add_c%0d got=%h exp=%h", i, ctl, seq[i]);
      end
    end
    step();
    checks++;
    if (w !== 1'b1) begin
      errors++; $display("FAIL add_done w=%b exp=1", w);
    end
  endtask

  task automatic test_and();
    logic [19:0] seq [0:5];
    seq = '{ev(0, 0, 0, ST_NONE, 0, 0), ev(0, 3'b110, 0, ST_GETA, 0, 0),
            ev(0, 3'b101, 0, ST_GETB, 0, 0), ev(0, 0, 0, ST_EXEC, 2'b00, 2'b10),
            ev(0, 0, 3'b111, ST_WRREG, 0, 0), ev(1, 0, 0, ST_NONE, 0, 0)};
    in = 16'hB6E5; load = 1'b1; s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      load = 1'b0; s = 1'b0;
      checks++;
      if (ctl !== seq[i]) begin
        errors++; $display("FAIL and_c%0d got=%h exp=%h", i, ctl, seq[i]);
      end
    end
  endtask

  task automatic test_cmp();
    logic [19:0] seq [0:4];
    seq = '{ev(0, 0, 0, ST_NONE, 0, 0), ev(0, 3'b001, 0, ST_GETA, 0, 0),
            ev(0, 3'b000, 0, ST_GETB, 0, 0), ev(0, 0, 0, ST_CMP, 2'b00, 2'b01),
            ev(1, 0, 0, ST_NONE, 0, 0)};
    in = 16'hA900; load = 1'b1; s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0; s = 1'b0;
      checks++;
      if (ctl !== seq[i]) begin
        errors++; $display("FAIL cmp_c%0d got=%h exp=%h", i, ctl, seq[i]);
      end
    end
  endtask

  task automatic test_movreg_mvn();
    logic [19:0] seq [0:3];
    // MOV R3,R2,LSR#1
    seq = '{ev(0, 0, 0, ST_NONE, 0, 0), ev(0, 3'b010, 0, ST_GETB, 0, 0),
            ev(0, 0, 0, ST_MOVR, 2'b10, 2'b00), ev(0, 0, 3'b011, ST_WRREG, 0, 0)};
    in = 16'hC072; load = 1'b1; s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      load = 1'b0; s = 1'b0;
      checks++;
      if (ctl !== seq[i]) begin
        errors++; $display("FAIL movreg_c%0d got=%h exp=%h", i, ctl, seq[i]);
      end
    end
    step();
    checks++;
    if (w !== 1'b1) begin
      errors++; $display("FAIL movreg_done w=%b exp=1", w);
    end
    // MVN R4,R5
    seq = '{ev(0, 0, 0, ST_NONE, 0, 0), ev(0, 3'b101, 0, ST_GETB, 0, 0),
            ev(0, 0, 0, ST_EXEC, 2'b00, 2'b11), ev(0, 0, 3'b100, ST_WRREG, 0, 0)};
    in = 16'hB885; load = 1'b1; s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      load = 1'b0; s = 1'b0;
      checks++;
      if (ctl !== seq[i]) begin
        errors++; $display("FAIL mvn_c%0d got=%h exp=%h", i, ctl, seq[i]);
      end
    end
    step();
    checks++;
    if (w !== 1'b1) begin
      errors++; $display("FAIL mvn_done w=%b exp=1", w);
    end
  endtask

  task automatic test_load_ignored();
    in = 16'hD007; load = 1'b1; s = 1'b1;
    step();
    s = 1'b0; in = 16'hD1FE;
    step();
    load = 1'b0;
    checks++;
    if (datapath_in !== 16'h0007 || writenum !== 3'b000) begin
      errors++; $display("FAIL load_busy dpin=%h wn=%b exp=0007/000", datapath_in, writenum);
    end
    step();
    s = 1'b1;
    step();
    s = 1'b0;
    step();
    checks++;
    if (datapath_in !== 16'h0007 || write !== 1'b1) begin
      errors++; $display("FAIL rerun_ir dpin=%h write=%b exp=0007/1", datapath_in, write);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [19:0] seq [0:4];
    seq = '{ev(0, 0, 0, ST_NONE, 0, 0), ev(0, 0, 3'b001, ST_WRIMM, 0, 0),
            ev(1, 0, 0, ST_NONE, 0, 0), ev(0, 0, 0, ST_NONE, 0, 0),
            ev(0, 0, 3'b001, ST_WRIMM, 0, 0)};
    in = 16'hD1FE; load = 1'b1; s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0;
      checks++;
      if (ctl !== seq[i]) begin
        errors++; $display("FAIL b2b_c%0d got=%h exp=%h", i, ctl, seq[i]);
      end
    end
    s = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_add();
    in = 16'hA148; load = 1'b1; s = 1'b1;
    step();
    load = 1'b0; s = 1'b0;
    step();
    step();
    checks++;
    if (loadb !== 1'b1 || w !== 1'b0) begin
      errors++; $display("FAIL midadd_getb loadb=%b w=%b exp=1/0", loadb, w);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (w !== 1'b1 || loadb !== 1'b0 || datapath_in !== 16'h0000) begin
      errors++; $display("FAIL midadd_rst w=%b loadb=%b dpin=%h exp=1/0/0000", w, loadb, datapath_in);
    end
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (write !== 1'b0 || w !== 1'b1) begin
        errors++; $display("FAIL midadd_after_c%0d write=%b w=%b exp=0/1", i, write, w);
      end
    end
  endtask

  task automatic test_illegal(input logic [15:0] word);
    in = word; load = 1'b1; s = 1'b1;
    step();
    load = 1'b0; s = 1'b0;
    checks++;
    if (w !== 1'b0) begin
      errors++; $display("FAIL illegal_%h_decode w=%b exp=0", word, w);
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ctl !== {1'b0, 1'b1, 18'b0}) begin
        errors++; $display("FAIL illegal_%h_halt_c%0d got=%h exp=%h", word, i, ctl, {1'b0, 1'b1, 18'b0});
      end
    end
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    checks++;
    if (w !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL illegal_%h_release w=%b err=%b exp=1/0", word, w, err);
    end
`else
    step();
    step();
    checks++;
    if (ctl !== ev(1, 0, 0, ST_NONE, 0, 0)) begin
      errors++; $display("FAIL illegal_%h_nop got=%h exp=%h", word, ctl, ev(1, 0, 0, ST_NONE, 0, 0));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_movimm(16'hD007, 3'b000, 16'h0007);
    test_movimm(16'hD1FE, 3'b001, 16'hFFFE);
    test_add();
    test_cmp();
    test_and();
    test_movreg_mvn();
    test_load_ignored();
    test_back_to_back();
    test_reset_mid_add();
    test_illegal(16'h0000);
    test_illegal(16'hC800);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
